// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, write-back bypass
// into the captured operands, and saturating stall/flush event counters.
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [XLEN-1:0]  ID_rdata1,
    input  logic [XLEN-1:0]  ID_rdata2,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_MemtoReg,
    input  logic             ID_ALUSrc,
    input  logic             ID_Branch,
    input  logic [3:0]       ID_ALUOp,
    input  logic             MEM_WB_RegWrite,
    input  logic [4:0]       MEM_WB_rd,
    input  logic [XLEN-1:0]  MEM_WB_wdata,
    input  logic             flush,
    output logic             ID_EX_valid,
    output logic [XLEN-1:0]  ID_EX_pc,
    output logic [4:0]       ID_EX_rs1,
    output logic [4:0]       ID_EX_rs2,
    output logic [4:0]       ID_EX_rd,
    output logic [XLEN-1:0]  ID_EX_rdata1,
    output logic [XLEN-1:0]  ID_EX_rdata2,
    output logic [XLEN-1:0]  ID_EX_imm,
    output logic             ID_EX_RegWrite,
    output logic             ID_EX_MemRead,
    output logic             ID_EX_MemWrite,
    output logic             ID_EX_MemtoReg,
    output logic             ID_EX_ALUSrc,
    output logic             ID_EX_Branch,
    output logic [3:0]       ID_EX_ALUOp,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            alusrc;
        logic            branch;
        logic [3:0]      aluop;
    } ex_t;

    ex_t             ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic            hz;
    logic            byp1, byp2;

    always_comb begin
        hz = ex_q.memread & (ex_q.rd != 5'd0) & ID_valid &
             ((ID_use_rs1 & (ID_rs1 == ex_q.rd)) |
              (ID_use_rs2 & (ID_rs2 == ex_q.rd)));
    end

    assign stall = hz & ~flush & ~rst;

    // x0 is hard-wired zero, so a write-back to it must never be forwarded.
    assign byp1 = MEM_WB_RegWrite & (MEM_WB_rd != 5'd0) & (MEM_WB_rd == ID_rs1);
    assign byp2 = MEM_WB_RegWrite & (MEM_WB_rd != 5'd0) & (MEM_WB_rd == ID_rs2);

    always_comb begin
        ex_d = '0;
        if (!(flush || hz)) begin
            ex_d.valid    = ID_valid;
            ex_d.pc       = ID_pc;
            ex_d.rs1      = ID_rs1;
            ex_d.rs2      = ID_rs2;
            ex_d.rd       = ID_rd;
            ex_d.rdata1   = byp1 ? MEM_WB_wdata : ID_rdata1;
            ex_d.rdata2   = byp2 ? MEM_WB_wdata : ID_rdata2;
            ex_d.imm      = ID_imm;
            ex_d.regwrite = ID_RegWrite;
            ex_d.memread  = ID_MemRead;
            ex_d.memwrite = ID_MemWrite;
            ex_d.memtoreg = ID_MemtoReg;
            ex_d.alusrc   = ID_ALUSrc;
            ex_d.branch   = ID_Branch;
            ex_d.aluop    = ID_ALUOp;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ID_EX_valid    = ex_q.valid;
    assign ID_EX_pc       = ex_q.pc;
    assign ID_EX_rs1      = ex_q.rs1;
    assign ID_EX_rs2      = ex_q.rs2;
    assign ID_EX_rd       = ex_q.rd;
    assign ID_EX_rdata1   = ex_q.rdata1;
    assign ID_EX_rdata2   = ex_q.rdata2;
    assign ID_EX_imm      = ex_q.imm;
    assign ID_EX_RegWrite = ex_q.regwrite;
    assign ID_EX_MemRead  = ex_q.memread;
    assign ID_EX_MemWrite = ex_q.memwrite;
    assign ID_EX_MemtoReg = ex_q.memtoreg;
    assign ID_EX_ALUSrc   = ex_q.alusrc;
    assign ID_EX_Branch   = ex_q.branch;
    assign ID_EX_ALUOp    = ex_q.aluop;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule
